uart_transmitter: RTL and testbench

- 8N1 UART transmitter. It is the transmit-side counterpart of the comm-clock UART receiver, and serialises bytes from the miner's comm logic onto uart_tx.
- A small FIFO decouples byte producers from line timing. Queued bytes are sent back-to-back, with no idle gap between frames.
- One clock domain (comm clock) with a synchronous active-high reset.

---
 rtl/uart_transmitter.sv | 201 ++++++++++++++++++++
 tb/tb_uart_transmitter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a small byte FIFO. Queued bytes leave back-to-back,
// and the serial line plus both status flags come straight from flops.
module uart_transmitter #(
    parameter int comm_clk_frequency = 75000000,
    parameter int baud_rate          = 115200,
    parameter int fifo_depth_log2    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_new_byte,
    input  logic [7:0] rx_byte,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       uart_tx
);

    localparam int AW      = fifo_depth_log2;
    localparam int c_depth = 1 << fifo_depth_log2;

    localparam logic [15:0] c_baud_delay = 16'(comm_clk_frequency / baud_rate - 1);
    localparam logic [15:0] c_baud_one   = 16'd1;
    localparam logic [15:0] c_baud_zero  = 16'd0;

    localparam logic [AW:0]   c_count_full = (AW + 1)'(c_depth);
    localparam logic [AW:0]   c_count_zero = (AW + 1)'(0);
    localparam logic [AW:0]   c_count_one  = (AW + 1)'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    r_mem [c_depth];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [1:0]  r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;

    logic r_tx;
    logic r_tx_ready;
    logic r_tx_busy;

    logic        w_push;
    logic        w_pop;
    logic        w_fifo_nempty;
    logic        w_bit_end;
    logic [7:0]  w_head;
    logic [AW:0] w_count_nxt;
    logic [1:0]  w_state_nxt;
    logic [15:0] w_baud_nxt;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  w_shift_nxt;
    logic        w_tx_nxt;

    assign w_push        = rx_new_byte & r_tx_ready;
    assign w_fifo_nempty = (r_count != c_count_zero);
    assign w_bit_end     = (r_baud_cnt == c_baud_delay);
    assign w_head        = r_mem[r_rd_ptr];

    // Framing state machine; a pop happens from IDLE or on the last STOP cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = c_baud_zero;
                if (w_fifo_nempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = c_baud_zero;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + c_baud_one;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = c_baud_zero;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + c_baud_one;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = c_baud_zero;
                    // Chain straight into the next start bit so frames abut.
                    if (w_fifo_nempty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + c_baud_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = c_baud_zero;
            end
        endcase
    end

    // FIFO occupancy after this edge's push and pop.
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_count_one;
            2'b01:   w_count_nxt = r_count - c_count_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Line level for the state being entered, so uart_tx can be a plain flop.
    always_comb begin
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_byte;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= c_count_zero;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_nxt;
        end
    end

    // Framing state, baud counter, bit index and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= c_baud_zero;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    // Registered line and status outputs, computed from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx       <= w_tx_nxt;
            r_tx_ready <= (w_count_nxt != c_count_full);
            r_tx_busy  <= (w_state_nxt != S_IDLE) | (w_count_nxt != c_count_zero);
        end
    end

    assign uart_tx  = r_tx;
    assign tx_ready = r_tx_ready;
    assign tx_busy  = r_tx_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: stimulus queues expected bytes, a line receiver pops and compares.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset, rx_new_byte, tx_ready, tx_busy, uart_tx;
    logic [7:0] rx_byte;
    logic       reset2, rx_new_byte2, tx_ready2, tx_busy2, uart_tx2;
    logic [7:0] rx_byte2;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    int         frames_seen = 0;
    bit         mon_abort = 1'b0;

    uart_transmitter #(
        .comm_clk_frequency(1000000),
        .baud_rate         (100000),
        .fifo_depth_log2   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_new_byte(rx_new_byte),
        .rx_byte    (rx_byte),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .uart_tx    (uart_tx)
    );

    uart_transmitter dut_def (
        .clk        (clk),
        .reset      (reset2),
        .rx_new_byte(rx_new_byte2),
        .rx_byte    (rx_byte2),
        .tx_ready   (tx_ready2),
        .tx_busy    (tx_busy2),
        .uart_tx    (uart_tx2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int start_at(input int i);
        if (i < starts.size()) return starts[i];
        return -1;
    endfunction

    // Called at a negedge; strobes one byte into the edge that follows.
    task automatic push(input logic [7:0] b, input logic exp_acc, output int n);
        check("tx_ready_at_push", {31'd0, tx_ready}, {31'd0, exp_acc});
        rx_new_byte = 1'b1;
        rx_byte     = b;
        if (exp_acc) exp_q.push_back(b);
        @(negedge clk);
        rx_new_byte = 1'b0;
        n = cyc;
    endtask

    task automatic wait_idle(input int bound, output int t);
        int k;
        k = 0;
        while (tx_busy !== 1'b0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (k >= bound) check("idle_timeout", 32'd0, 32'd1);
        t = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Line receiver: captures every cycle of a frame, checks level and stability per bit.
    initial begin : rx_monitor
        logic       prev;
        logic [9:0] got;
        logic [9:0] want;
        logic       stable;
        logic       have_exp;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && uart_tx === 1'b0) begin
                starts.push_back(cyc);
                frames_seen++;
                have_exp = (exp_q.size() > 0);
                e = have_exp ? exp_q.pop_front() : 8'h00;
                want = {1'b1, e, 1'b0};
                got = 10'd0;
                stable = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    for (int j = 0; j < 10; j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (j == 0) got[i] = uart_tx;
                        else if (uart_tx !== got[i]) stable = 1'b0;
                    end
                end
                if (mon_abort) begin
                    mon_abort = 1'b0;
                end else begin
                    if (!have_exp) check("unexpected_frame", 32'd0, 32'd1);
                    check("frame_bits", {22'd0, got}, {22'd0, want});
                    check("bits_stable", {31'd0, stable}, 32'd1);
                end
            end
            prev = uart_tx;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, n0, t, t0, tp, base, fs, k;
        logic level, hi_ok;

        reset = 1'b1; rx_new_byte = 1'b0; rx_byte = 8'h00;
        reset2 = 1'b1; rx_new_byte2 = 1'b0; rx_byte2 = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0; reset2 = 1'b0;
        check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("reset2_uart_tx", {31'd0, uart_tx2}, 32'd1);
        check("reset2_tx_busy", {31'd0, tx_busy2}, 32'd0);
        @(negedge clk);

        // Single byte with exact latency.
        base = starts.size();
        push(8'hA5, 1'b1, n);
        check("t1_busy_after_push", {31'd0, tx_busy}, 32'd1);
        check("t1_line_high_at_push", {31'd0, uart_tx}, 32'd1);
        wait_idle(300, t);
        check("t1_start_cycle", start_at(base), n + 1);
        check("t1_busy_fall_cycle", t, n + 101);

        // Back-to-back frames, no idle gap.
        base = starts.size();
        push(8'h00, 1'b1, n0);
        push(8'h55, 1'b1, n);
        push(8'hFF, 1'b1, n);
        wait_idle(600, t);
        check("t2_start_cycle", start_at(base), n0 + 1);
        check("t2_gap_1_2", start_at(base + 1) - start_at(base), 100);
        check("t2_gap_2_3", start_at(base + 2) - start_at(base + 1), 100);
        check("t2_busy_fall_cycle", t, n0 + 301);

        // Overflow: 01 popped at once, 02..05 fill the FIFO, 06 dropped.
        base = starts.size();
        push(8'h01, 1'b1, n0);
        push(8'h02, 1'b1, n);
        push(8'h03, 1'b1, n);
        push(8'h04, 1'b1, n);
        push(8'h05, 1'b1, n);
        push(8'h06, 1'b0, n);
        check("t3_ready_low_full", {31'd0, tx_ready}, 32'd0);
        wait_until(n0 + 100);
        check("t3_ready_before_pop", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        check("t3_ready_after_pop", {31'd0, tx_ready}, 32'd1);
        wait_idle(800, t);
        check("t3_frame_count", starts.size() - base, 5);
        check("t3_busy_fall_cycle", t, n0 + 501);

        // Push coinciding with the STOP-end pop at count=1 keeps count at 1.
        base = starts.size();
        push(8'hAA, 1'b1, n0);
        push(8'hBB, 1'b1, n);
        wait_until(n0 + 100);
        push(8'hCC, 1'b1, n);
        push(8'hDD, 1'b1, n);
        push(8'hEE, 1'b1, n);
        push(8'hFF, 1'b1, n);
        push(8'h77, 1'b0, n);
        wait_idle(900, t);
        check("t4_frame_count", starts.size() - base, 6);
        check("t4_busy_fall_cycle", t, n0 + 601);

        // Reset during data bit 3 of 3C with two bytes queued.
        push(8'h3C, 1'b1, n0);
        push(8'h81, 1'b1, n);
        push(8'h42, 1'b1, n);
        wait_until(n0 + 44);
        reset = 1'b1;
        mon_abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("t5_uart_tx_after_reset", {31'd0, uart_tx}, 32'd1);
        check("t5_ready_after_reset", {31'd0, tx_ready}, 32'd1);
        check("t5_busy_after_reset", {31'd0, tx_busy}, 32'd0);
        fs = frames_seen;
        hi_ok = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) hi_ok = 1'b0;
        end
        check("t5_line_quiet", {31'd0, hi_ok}, 32'd1);
        check("t5_no_new_frames", frames_seen, fs);
        base = starts.size();
        push(8'h5A, 1'b1, n);
        wait_idle(300, t);
        check("t5_restart_start", start_at(base), n + 1);
        check("t5_queue_drained", exp_q.size(), 0);

        // Default parameters: 651-cycle bits, 6510-cycle frame (0x55 toggles every bit).
        check("t6_ready2", {31'd0, tx_ready2}, 32'd1);
        rx_new_byte2 = 1'b1;
        rx_byte2 = 8'h55;
        @(negedge clk);
        rx_new_byte2 = 1'b0;
        n = cyc;
        k = 0;
        while (uart_tx2 !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        t0 = cyc;
        check("t6_start_cycle", t0, n + 1);
        tp = t0;
        level = 1'b0;
        for (int b = 1; b < 10; b++) begin
            k = 0;
            while (uart_tx2 === level && k < 1000) begin @(negedge clk); k++; end
            check("t6_bit_period", cyc - tp, 651);
            tp = cyc;
            level = ~level;
        end
        k = 0;
        while (tx_busy2 !== 1'b0 && k < 1000) begin @(negedge clk); k++; end
        check("t6_stop_period", cyc - tp, 651);
        check("t6_frame_length", cyc - t0, 6510);
        check("t6_line_idle", {31'd0, uart_tx2}, 32'd1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
